// File: rtl/jc_pkg.sv
// Shared types and code-classification helpers for the Johnson counter phase decoder.
// A legal Johnson code is a run of ones at the bottom or a run of ones at the top.
package jc_pkg;

    typedef enum logic [0:0] {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

    localparam int JC_N  = 4;
    localparam int JC_IW = $clog2(2 * JC_N);

    localparam logic [JC_N-1:0] JC_ONE  = {{(JC_N-1){1'b0}}, 1'b1};
    localparam logic [JC_IW:0]  JC_RING = (JC_IW+1)'(2 * JC_N);

    // Ones filled from the LSB (q & (q+1) == 0) or zeros filled from the LSB.
    function automatic logic jc_is_legal(input logic [JC_N-1:0] q);
        logic [JC_N-1:0] nq;
        nq = ~q;
        return (((q & (q + JC_ONE)) == {JC_N{1'b0}}) ||
                ((nq & (nq + JC_ONE)) == {JC_N{1'b0}}));
    endfunction

    // Filling half counts ones upward; draining half counts down from 2N.
    function automatic logic [JC_IW-1:0] jc_to_idx(input logic [JC_N-1:0] q);
        logic [JC_IW:0] pop;
        logic [JC_IW:0] full;
        pop = {(JC_IW+1){1'b0}};
        for (int i = 0; i < JC_N; i++) begin
            pop = pop + {{JC_IW{1'b0}}, q[i]};
        end
        if (q[JC_N-1]) begin
            full = JC_RING - pop;
        end else begin
            full = pop;
        end
        return full[JC_IW-1:0];
    endfunction

endpackage

// File: rtl/jc_code_decode.sv
// Combinational classifier: Johnson code -> {legal, phase index}.
module jc_code_decode
    import jc_pkg::*;
(
    input  logic [JC_N-1:0]  code,
    output logic             legal,
    output logic [JC_IW-1:0] idx
);

    assign legal = jc_is_legal(code);
    assign idx   = jc_to_idx(code);

endmodule

// File: rtl/jc_phase_decoder.sv
// Registered Johnson phase decoder with step checking, lock tracking and ring counting.
// prev_* remembers the last legal sample so each new code can be checked as a single step.
module jc_phase_decoder
    import jc_pkg::*;
#(
    parameter int N          = JC_N,
    parameter int LOCK_CNT   = 8,
    parameter int CW         = 16,
    parameter int ALLOW_HOLD = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N-1:0]              q_in,
    input  logic                      clr_err,
    output logic [$clog2(2*N)-1:0]    phase_idx,
    output logic [2*N-1:0]            phase_onehot,
    output logic                      code_ok,
    output logic                      step_err,
    output logic                      err_sticky,
    output logic                      wrap,
    output logic                      locked,
    output logic [CW-1:0]             cycle_cnt
);

    localparam int IW = $clog2(2 * N);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam logic [IW-1:0] IDX_ONE  = {{(IW-1){1'b0}}, 1'b1};
    localparam logic [IW-1:0] LAST_IDX = IW'(2 * N - 1);
    localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_CNT);
    localparam logic [GW-1:0] GOOD_ONE = {{(GW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    logic              dec_legal_s;
    logic [IW-1:0]     dec_idx_s;
    logic [IW-1:0]     next_idx_s;
    logic              is_step_s;
    logic              is_hold_s;
    logic              err_s;

    logic              prev_vld_q, prev_vld_d;
    logic [IW-1:0]     prev_idx_q, prev_idx_d;
    logic [IW-1:0]     phase_idx_q, phase_idx_d;
    logic [2*N-1:0]    phase_onehot_q, phase_onehot_d;
    logic              code_ok_q, code_ok_d;
    logic              step_err_q, step_err_d;
    logic              err_sticky_q, err_sticky_d;
    logic              wrap_q, wrap_d;
    logic              locked_q, locked_d;
    logic [CW-1:0]     cycle_cnt_q, cycle_cnt_d;
    lock_state_e       state_q, state_d;
    logic [GW-1:0]     good_cnt_q, good_cnt_d;

    jc_code_decode u_decode (
        .code  (q_in),
        .legal (dec_legal_s),
        .idx   (dec_idx_s)
    );

    // Step checker, output decode and counters.
    always_comb begin
        next_idx_s     = (prev_idx_q == LAST_IDX) ? {IW{1'b0}} : (prev_idx_q + IDX_ONE);
        is_step_s      = dec_legal_s && prev_vld_q && (dec_idx_s == next_idx_s);
        is_hold_s      = dec_legal_s && prev_vld_q && (dec_idx_s == prev_idx_q);
        err_s          = !dec_legal_s ||
                         (prev_vld_q && !is_step_s && !(is_hold_s && (ALLOW_HOLD != 0)));

        prev_vld_d     = dec_legal_s;
        prev_idx_d     = prev_idx_q;
        phase_idx_d    = phase_idx_q;
        phase_onehot_d = {(2*N){1'b0}};
        if (dec_legal_s) begin
            prev_idx_d                = dec_idx_s;
            phase_idx_d               = dec_idx_s;
            phase_onehot_d[dec_idx_s] = 1'b1;
        end else begin
            prev_idx_d = prev_idx_q;
        end

        code_ok_d  = dec_legal_s;
        step_err_d = err_s;
        wrap_d     = is_step_s && (prev_idx_q == LAST_IDX);

        // An error in the same cycle wins over clr_err.
        if (err_s) begin
            err_sticky_d = 1'b1;
        end else if (clr_err) begin
            err_sticky_d = 1'b0;
        end else begin
            err_sticky_d = err_sticky_q;
        end

        if (clr_err) begin
            cycle_cnt_d = {CW{1'b0}};
        end else if (wrap_d) begin
            cycle_cnt_d = cycle_cnt_q + CNT_ONE;
        end else begin
            cycle_cnt_d = cycle_cnt_q;
        end
    end

    // Lock FSM: counts consecutive legal steps; holds and seeds leave the count alone.
    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        case (state_q)
            UNLOCKED: begin
                if (err_s) begin
                    good_cnt_d = {GW{1'b0}};
                end else if (is_step_s) begin
                    if (good_cnt_q < GOOD_MAX) begin
                        good_cnt_d = good_cnt_q + GOOD_ONE;
                    end else begin
                        good_cnt_d = good_cnt_q;
                    end
                    if (good_cnt_d == GOOD_MAX) begin
                        state_d = LOCKED;
                    end else begin
                        state_d = UNLOCKED;
                    end
                end else begin
                    good_cnt_d = good_cnt_q;
                end
            end
            LOCKED: begin
                if (err_s) begin
                    state_d    = UNLOCKED;
                    good_cnt_d = {GW{1'b0}};
                end else begin
                    state_d = LOCKED;
                end
            end
            default: begin
                state_d    = UNLOCKED;
                good_cnt_d = {GW{1'b0}};
            end
        endcase
        locked_d = (state_d == LOCKED);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_vld_q     <= 1'b0;
            prev_idx_q     <= {IW{1'b0}};
            phase_idx_q    <= {IW{1'b0}};
            phase_onehot_q <= {(2*N){1'b0}};
            code_ok_q      <= 1'b0;
            step_err_q     <= 1'b0;
            err_sticky_q   <= 1'b0;
            wrap_q         <= 1'b0;
            locked_q       <= 1'b0;
            cycle_cnt_q    <= {CW{1'b0}};
            state_q        <= UNLOCKED;
            good_cnt_q     <= {GW{1'b0}};
        end else begin
            prev_vld_q     <= prev_vld_d;
            prev_idx_q     <= prev_idx_d;
            phase_idx_q    <= phase_idx_d;
            phase_onehot_q <= phase_onehot_d;
            code_ok_q      <= code_ok_d;
            step_err_q     <= step_err_d;
            err_sticky_q   <= err_sticky_d;
            wrap_q         <= wrap_d;
            locked_q       <= locked_d;
            cycle_cnt_q    <= cycle_cnt_d;
            state_q        <= state_d;
            good_cnt_q     <= good_cnt_d;
        end
    end

    assign phase_idx    = phase_idx_q;
    assign phase_onehot = phase_onehot_q;
    assign code_ok      = code_ok_q;
    assign step_err     = step_err_q;
    assign err_sticky   = err_sticky_q;
    assign wrap         = wrap_q;
    assign locked       = locked_q;
    assign cycle_cnt    = cycle_cnt_q;

endmodule

// File: doc/jc_phase_decoder.md
# jc_phase_decoder

Downstream consumer of the 4-bit Johnson counter. Samples the counter's code every clock, decodes it to a phase index and a one-hot phase vector, and checks each transition against the legal Johnson sequence. Tracks sequence lock, counts completed rings, and flags illegal codes and bad steps, so later stages can use the counter as a trusted 2N-phase timing source.

## Interface
- N, 4, Johnson counter width; ring length is 2N states.
- LOCK_CNT, 8, consecutive legal steps required to assert `locked`.
- CW, 16, width of `cycle_cnt`.
- ALLOW_HOLD, 0, 1 = repeated code is legal (no step, no error).
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- q_in  in  N  Johnson code from upstream counter.
- clr_err  in  1  clears `err_sticky` and `cycle_cnt`.
- phase_idx  out  $clog2(2N)  decoded phase 0..2N-1.
- phase_onehot  out  2N  one-hot phase; all-zero on illegal code.
- code_ok  out  1  sampled code is a legal Johnson state.
- step_err  out  1  one-cycle pulse on illegal code or bad transition.
- err_sticky  out  1  set by any `step_err`; cleared only by `clr_err` or reset.
- wrap  out  1  one-cycle pulse on a legal step 2N-1 -> 0.
- locked  out  1  sequence lock status.
- cycle_cnt  out  CW  count of `wrap` events; wraps modulo 2^CW.

## Operation
- Upstream sequence, fixed: next = {q[N-2:0], ~q[N-1]}. For N=4: 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, then back to 0000.
- The code is legal iff (q & (q+1)) == 0, or (~q & (~q+1)) == 0, evaluated in N bits.
- Decode:
  - MSB=0: idx = popcount(q).
  - MSB=1: idx = 2N - popcount(q).
- Example decodes: 1111 -> 4; 1000 -> 7.
- `prev_vld` and `prev_idx` hold the last legal sample.
- Step check, applied only when `prev_vld`=1:
  - Legal step: idx == (prev_idx+1) mod 2N.
  - Hold: idx == prev_idx. Legal if ALLOW_HOLD=1, otherwise an error.
  - Anything else is an error.
- Illegal code:
  - `code_ok`=0, `phase_onehot`=0, `phase_idx` holds its last value.
  - `step_err`=1.
  - `prev_vld` cleared, so the next legal code re-seeds without an error.
- First legal sample after reset or after an illegal code: seeds `prev`; no check and no error.
- Lock FSM, states UNLOCKED and LOCKED; `good_cnt` saturates at LOCK_CNT.
  - UNLOCKED: each legal step increments `good_cnt`. Reaching LOCK_CNT moves to LOCKED.
  - A hold (ALLOW_HOLD=1) neither increments nor clears `good_cnt`.
  - Any error moves to UNLOCKED and zeroes `good_cnt`.
  - LOCKED: any error moves to UNLOCKED and zeroes `good_cnt`.
- `cycle_cnt` increments only on a legal 7 -> 0 step (2N-1 -> 0), together with `wrap`.
- `clr_err` alone: `err_sticky`=0 and `cycle_cnt`=0 next cycle.
- `clr_err` in the same cycle as an error: `err_sticky` stays 1. `cycle_cnt` still clears.

## Timing
- All outputs are registered. Latency is 1 cycle: `q_in` sampled at edge k appears on outputs after edge k.
- `locked` rises in the same cycle as the outputs of the LOCK_CNT-th legal step.
- Reset values:
  - `phase_idx`=0, `phase_onehot`=0, `code_ok`=0.
  - `step_err`=0, `err_sticky`=0, `wrap`=0, `locked`=0, `cycle_cnt`=0.
  - FSM UNLOCKED, `prev_vld`=0, `good_cnt`=0.
- Reset asserted mid-run: all state returns to reset values at the next edge. The first sample after release is a seed, never an error.
- `step_err` and `wrap` are single-cycle pulses and are mutually exclusive.

## Structure
- Package `jc_pkg` holds:
  - Lock state enum (UNLOCKED, LOCKED).
  - Default N, with IW = $clog2(2N) derived from it.
  - Functions `jc_is_legal` and `jc_to_idx`.
- Sub-module `jc_code_decode`: combinational, N-bit code -> {legal, idx}, built on the package functions.
- Top-level `jc_phase_decoder` contains the registers, step checker, lock FSM and counters.

## Test plan
- Drive from the Johnson counter, 10 ns clock, release reset:
  - First output: `phase_idx`=0, `phase_onehot`=00000001, `code_ok`=1, `step_err`=0.
  - `locked`=1 after the 8th step.
  - `wrap` pulses each 1000 -> 0000 step; `cycle_cnt` reads 1, 2, 3.
- Force `q_in`=0101 for one cycle:
  - That cycle: `code_ok`=0, `phase_onehot`=0, `step_err`=1, `err_sticky`=1, `locked`=0.
  - Next legal code re-seeds with no error.
- Skip step 0001 -> 0111: `step_err`=1 with `phase_idx`=3. Relock needs 8 further legal steps.
- Hold 0011 for 2 cycles:
  - ALLOW_HOLD=0: `step_err` on the repeat.
  - ALLOW_HOLD=1: no error, `good_cnt` unchanged.
- `clr_err` together with an illegal code: `err_sticky` stays 1. `clr_err` alone: `err_sticky`=0 and `cycle_cnt`=0.
- Assert reset mid-ring at idx 5:
  - Next cycle all outputs read 0.
  - After release, the first sample (e.g. 0000) gives `step_err`=0 and `locked`=0.
